// File: rtl/reservation_station_pkg.sv
// Shared types for the reservation station: dispatcher entry, stored entry and issue payload.
package reservation_station_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned ROB_TAG_LEN = 5;
    localparam int unsigned FUNC_W      = 4;
    localparam int unsigned RS_SIZE_DEF = 4;

    typedef enum logic [1:0] {
        FU_ALU  = 2'd0,
        FU_MULT = 2'd1,
        FU_BTU  = 2'd2,
        FU_LSU  = 2'd3
    } fu_t;

    typedef logic [ROB_TAG_LEN-1:0] rob_tag_t;
    typedef logic [XLEN-1:0]        word_t;

    typedef struct packed {
        fu_t               fu;
        logic [FUNC_W-1:0] func;
        logic [2:0]        func3;
        rob_tag_t          tag_dest;
        rob_tag_t          tag_src1;
        rob_tag_t          tag_src2;
        logic              ready_src1;
        logic              ready_src2;
        word_t             value_src1;
        word_t             value_src2;
        word_t             imm;
        word_t             pc;
        word_t             npc;
        rob_tag_t          insn_tag;
    } inst_rs_t;

    typedef struct packed {
        logic     valid;
        inst_rs_t inst;
    } rs_entry_t;

    typedef struct packed {
        logic [FUNC_W-1:0] func;
        logic [2:0]        func3;
        word_t             value_src1;
        word_t             value_src2;
        word_t             imm;
        word_t             pc;
        word_t             npc;
        rob_tag_t          tag_dest;
        rob_tag_t          insn_tag;
    } rs_issue_pack_t;

endpackage

// File: rtl/reservation_station_if.sv
// Dispatcher, CDB and FU-issue signals of one reservation station.
interface reservation_station_if
    import reservation_station_pkg::*;
#(
    parameter int unsigned RS_SIZE = RS_SIZE_DEF
);
    localparam int unsigned CNT_W = $clog2(RS_SIZE) + 1;

    logic           load;
    inst_rs_t       inst_rs;
    logic           is_full;
    logic           cdb_valid;
    rob_tag_t       cdb_tag;
    word_t          cdb_value;
    logic           flush;
    logic           fu_ready;
    logic           issue_valid;
    rs_issue_pack_t issue_pack;
    logic [CNT_W-1:0] entries_used;

    modport master (
        output load, inst_rs, cdb_valid, cdb_tag, cdb_value, flush, fu_ready,
        input  is_full, issue_valid, issue_pack, entries_used
    );

    modport slave (
        input  load, inst_rs, cdb_valid, cdb_tag, cdb_value, flush, fu_ready,
        output is_full, issue_valid, issue_pack, entries_used
    );

endinterface

// File: rtl/reservation_station_priority_sel.sv
// Lowest-index-first picker: one-hot grant of the lowest set request bit.
module reservation_station_priority_sel #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] req,
    output logic [N-1:0] grant,
    output logic         valid
);

    // Two's-complement trick isolates the lowest set bit.
    assign grant = req & (~req + N'(1));
    assign valid = |req;

endmodule

// File: rtl/reservation_station.sv
// Reservation station: buffers dispatched instructions, captures CDB operands,
// and issues the lowest-index ready entry to its functional unit.
module reservation_station
    import reservation_station_pkg::*;
#(
    parameter int unsigned RS_SIZE = RS_SIZE_DEF,
    parameter fu_t         FU_TYPE = FU_ALU
) (
    input  logic                clk,
    input  logic                reset,
    reservation_station_if.slave rs
);

    localparam int unsigned RS_IDX_W = $clog2(RS_SIZE);
    localparam int unsigned CNT_W    = RS_IDX_W + 1;

    rs_entry_t          entries [RS_SIZE];
    logic [RS_SIZE-1:0] valid_vec;
    logic [RS_SIZE-1:0] ready_vec;
    logic [RS_SIZE-1:0] free_gnt;
    logic [RS_SIZE-1:0] issue_gnt;
    logic               free_any;
    logic               issue_any;
    logic               alloc;
    logic               fire;
    logic               fu_ok;
    inst_rs_t           new_inst;
    rs_issue_pack_t     pack;
    logic [CNT_W-1:0]   used;

    always_comb begin
        valid_vec = '0;
        ready_vec = '0;
        fu_ok     = 1'b1;
        for (int i = 0; i < RS_SIZE; i++) begin
            valid_vec[i] = entries[i].valid;
            ready_vec[i] = entries[i].valid & entries[i].inst.ready_src1
                         & entries[i].inst.ready_src2;
            if (entries[i].valid && entries[i].inst.fu != FU_TYPE) fu_ok = 1'b0;
        end
    end

    reservation_station_priority_sel #(.N(RS_SIZE)) u_free_sel (
        .req   (~valid_vec),
        .grant (free_gnt),
        .valid (free_any)
    );

    reservation_station_priority_sel #(.N(RS_SIZE)) u_issue_sel (
        .req   (ready_vec),
        .grant (issue_gnt),
        .valid (issue_any)
    );

    // Same-cycle CDB bypass so a broadcast in the dispatch cycle is not lost.
    always_comb begin
        new_inst = rs.inst_rs;
        if (rs.cdb_valid && !rs.inst_rs.ready_src1 && rs.inst_rs.tag_src1 == rs.cdb_tag) begin
            new_inst.ready_src1 = 1'b1;
            new_inst.value_src1 = rs.cdb_value;
        end
        if (rs.cdb_valid && !rs.inst_rs.ready_src2 && rs.inst_rs.tag_src2 == rs.cdb_tag) begin
            new_inst.ready_src2 = 1'b1;
            new_inst.value_src2 = rs.cdb_value;
        end
    end

    // Free slot comes from pre-edge valid bits, so a slot freed by issue is not reused this edge.
    assign alloc = rs.load & free_any & ~rs.flush;
    assign fire  = issue_any & rs.fu_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < RS_SIZE; i++) entries[i] <= '0;
        end else if (rs.flush) begin
            for (int i = 0; i < RS_SIZE; i++) entries[i].valid <= 1'b0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (alloc && free_gnt[i]) begin
                    entries[i].valid <= 1'b1;
                    entries[i].inst  <= new_inst;
                end else if (entries[i].valid) begin
                    if (fire && issue_gnt[i]) entries[i].valid <= 1'b0;
                    if (rs.cdb_valid && !entries[i].inst.ready_src1
                        && entries[i].inst.tag_src1 == rs.cdb_tag) begin
                        entries[i].inst.ready_src1 <= 1'b1;
                        entries[i].inst.value_src1 <= rs.cdb_value;
                    end
                    if (rs.cdb_valid && !entries[i].inst.ready_src2
                        && entries[i].inst.tag_src2 == rs.cdb_tag) begin
                        entries[i].inst.ready_src2 <= 1'b1;
                        entries[i].inst.value_src2 <= rs.cdb_value;
                    end
                end
            end
        end
    end

    // Winner's payload; all zeros when nothing is ready.
    always_comb begin
        pack = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (issue_gnt[i]) begin
                pack.func       = entries[i].inst.func;
                pack.func3      = entries[i].inst.func3;
                pack.value_src1 = entries[i].inst.value_src1;
                pack.value_src2 = entries[i].inst.value_src2;
                pack.imm        = entries[i].inst.imm;
                pack.pc         = entries[i].inst.pc;
                pack.npc        = entries[i].inst.npc;
                pack.tag_dest   = entries[i].inst.tag_dest;
                pack.insn_tag   = entries[i].inst.insn_tag;
            end
        end
    end

    always_comb begin
        used = '0;
        for (int i = 0; i < RS_SIZE; i++) used = used + CNT_W'(valid_vec[i]);
    end

    assign rs.is_full      = &valid_vec;
    assign rs.issue_valid  = issue_any;
    assign rs.issue_pack   = pack;
    assign rs.entries_used = used;

    a_no_load_when_full: assert property (@(posedge clk) disable iff (!reset)
        !(rs.load && rs.is_full))
        else $error("dispatcher protocol error: load while full");

    a_load_fu_type: assert property (@(posedge clk) disable iff (!reset)
        rs.load |-> (rs.inst_rs.fu == FU_TYPE))
        else $error("dispatcher protocol error: wrong fu class");

    a_entry_fu_type: assert property (@(posedge clk) disable iff (!reset) fu_ok)
        else $error("reservation station holds an entry of the wrong fu class");

endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- Receiving end of the dispatcher→RS interface. One instance per functional unit class (ALU, MULT, BTU, LSU).
- Accepts one INST_RS per cycle while load is high.
- Holds each instruction until both operands are available, capturing missing operands from the CDB broadcast.
- Issues one ready instruction per cycle to its FU under a valid/ready handshake, and reports full back to the dispatcher.

Parameters:
- RS_SIZE, 4: number of entries.
- RS_IDX_W, $clog2(RS_SIZE): entry index width.
- FU_TYPE, FU_ALU: FU class served. Used only by assertions; inst_rs.fu must equal FU_TYPE whenever load=1.

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  asynchronous, active-low. Asserted when 0.
- load  in  1  dispatcher write strobe; this is RS_load[FU_TYPE].
- inst_rs  in  INST_RS  entry from the dispatcher: fu, func, func3, tag_dest, tag_src1, tag_src2, ready_src1, ready_src2, value_src1, value_src2, imm, pc, npc, insn_tag.
- is_full  out  1  all entries valid; this is RS_is_full[FU_TYPE].
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tag  in  ROB_TAG_LEN  producer ROB tag.
- cdb_value  in  XLEN  broadcast result.
- flush  in  1  mispredict squash from ROB.
- fu_ready  in  1  FU can accept an instruction this cycle.
- issue_valid  out  1  issue_pack holds a ready instruction.
- issue_pack  out  RS_ISSUE_PACK  func, func3, value_src1, value_src2, imm, pc, npc, tag_dest, insn_tag.
- entries_used  out  RS_IDX_W+1  valid entry count, for perf counters.

Behaviour:
- State per entry:
  - valid
  - stored INST_RS fields
  - ready_src1/2 and value_src1/2
- Reset (reset=0, asynchronous):
  - all valid=0
  - is_full=0, issue_valid=0, issue_pack='0, entries_used=0
- Allocation:
  - On a posedge with load=1 and is_full=0, the lowest-index invalid entry is written.
  - The entry is visible from the next cycle.
  - load=1 while is_full=1 is ignored; an assertion flags it as a dispatcher protocol error.
- is_full is a function of registered valid bits only, with no combinational path from inputs. An issue in the same cycle does not clear is_full until the next cycle.
- Wakeup, applied every cycle to each valid entry with cdb_valid=1:
  - If ready_srcN=0 and tag_srcN==cdb_tag, then on the edge ready_srcN←1 and value_srcN←cdb_value.
  - Both operands may wake on the same broadcast.
- Bypass on allocation: if load and cdb_valid are high together and the incoming tag_srcN==cdb_tag with ready_srcN=0, the new entry is written with that operand already captured. A broadcast in the dispatch cycle is never lost.
- Issue selection:
  - Candidate: valid && ready_src1 && ready_src2, evaluated on registered state.
  - Lowest-index candidate wins.
  - issue_valid = any candidate.
  - issue_pack = the winner's fields, combinational from registered state.
- Handshake:
  - When issue_valid && fu_ready at the posedge, the winner's valid←0.
  - If issue_valid=0, issue_pack is driven '0.
  - If fu_ready=0, the selection holds stable; the same or a lower-index newly-ready entry may win next cycle.
- Latency:
  - Dispatch of a fully-ready instruction at edge t gives issue_valid in cycle t+1.
  - A CDB wakeup at edge t allows issue in cycle t+1.
- Simultaneous events in one cycle:
  - Allocate into the freed slot is not allowed in the same edge. Allocation targets only slots invalid before the edge.
  - Issue, allocate and wakeup may all occur on the same edge.
- Flush:
  - Synchronous, highest priority: clears all valid bits on the edge.
  - Suppresses a coincident load and wakeup.
  - issue_valid is still driven combinationally during the flush cycle. The ROB ignores squashed results.
- Mid-operation reset clears every entry immediately, without waiting for a clock.
- Counter: entries_used = popcount(valid). Range 0..RS_SIZE, no wrap.

Decomposition:
- Shared package (rs.svh, alongside dispatcher.svh):
  - RS_ENTRY typedef (INST_RS plus valid)
  - RS_ISSUE_PACK typedef
  - RS_SIZE default
- Sub-module rs_priority_sel: parameterised lowest-index-first picker, returning a one-hot grant plus a valid. It is instantiated twice: free-slot select and ready-entry select.

Test Plan:
- Reset, then dispatch ALU with ready_src1=1/value 5, ready_src2=1/value 7, tag_dest=3, fu_ready=1 → issue_valid=1 the next cycle with value_src1=5, value_src2=7, tag_dest=3; entries_used goes 1→0.
- Dispatch tag_src1=6 not ready; CDB tag 6 value 0xDEAD two cycles later → issue_valid=0 until the cycle after the broadcast, then value_src1=0xDEAD.
- Dispatch tag_src2=9 not ready with CDB tag 9 value 42 in the same cycle → entry issues the next cycle with value_src2=42 (bypass).
- Fill 4 entries, all unready, fu_ready=0 → is_full=1 and entries_used=4; load during full is ignored with an assertion fire; wake entry 2, assert fu_ready → entry 2 issues and is_full=0 the following cycle.
- Entries 0 and 3 ready, fu_ready toggling 0,1,1 → issue order 0 then 3; issue_pack is stable while fu_ready=0.
- Three entries valid, flush with a coincident load and CDB → entries_used=0 and issue_valid=0 the next cycle; reset pulsed low mid-cycle → outputs clear before the next edge.
